// File: rtl/dot_product.sv
// Dot-product engine: three word-wide SRAMs, an IDLE/LOAD/COMPUTE/DUMP controller and a
// 4-stage (read, multiply, add, write-back) lane pipeline. Define DOT_PRODUCT_DEBUG_EN for debug ports.

module dot_product_lane #(
    parameter int Din  = 8,
    parameter int Dout = 16
) (
    input  logic            clk,
    input  logic [Din-1:0]  a,
    input  logic [Din-1:0]  b,
    input  logic [Dout-1:0] old,
    input  logic            acc,
    output logic [Dout-1:0] sum
);
    logic [Dout-1:0] prod_d, prod_q, base_d, base_q, sum_d, sum_q;

    always_comb begin
        prod_d = Dout'(a) * Dout'(b);
        base_d = acc ? old : '0;
        sum_d  = prod_q + base_q;
    end

    always_ff @(posedge clk) begin
        prod_q <= prod_d;
        base_q <= base_d;
        sum_q  <= sum_d;
    end

    assign sum = sum_q;
endmodule

module dot_product #(
    parameter int Addr_Width           = 4,
    parameter int Para_Deg             = 2,
    parameter int Data_Width_In        = 8,
    parameter int Data_Width_Out       = 16,
    parameter int Nums_Data_in_bits    = 4,
    parameter int Nums_Pipeline_Stages = 4
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   Mem_Index_reset,
    input  logic                                   Computing,
    input  logic                                   load_old_output,
    input  logic                                   load_from_file,
    input  logic                                   write_to_file,
    input  logic [2*Para_Deg*Data_Width_In-1:0]    input_data_from_file,
    input  logic [Para_Deg*Data_Width_Out-1:0]     output_data_from_file,
    output logic [Para_Deg*Data_Width_Out-1:0]     output_data_to_file,
    output logic [Para_Deg*Data_Width_Out-1:0]     result,
`ifdef DOT_PRODUCT_DEBUG_EN
    output logic [3*Addr_Width-1:0]                test_r,
    output logic [3*Addr_Width-1:0]                test_w,
    output logic [2*Para_Deg*Data_Width_In-1:0]    test_data,
    output logic                                   en_write_test,
    output logic [Addr_Width:0]                    mem_index_test,
    output logic                                   test_en_read,
    output logic                                   test_signal,
`endif
    output logic [Nums_Data_in_bits:0]             state
);
    localparam int N     = 1 << Nums_Data_in_bits;
    localparam int W     = N / Para_Deg;
    localparam int T     = W + Nums_Pipeline_Stages - 1;
    localparam int SW    = Nums_Data_in_bits + 1;
    localparam int CW    = Addr_Width + 1;
    localparam int PW_IN = Para_Deg * Data_Width_In;

    localparam logic [CW-1:0]         CNT_LAST  = CW'(W - 1);
    localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
    localparam logic [SW-1:0]         ST_ISSUE  = SW'(W);
    localparam logic [SW-1:0]         ST_LAST   = SW'(T);
    localparam logic [SW-1:0]         ST_ONE    = SW'(1);
    localparam logic [Addr_Width-1:0] IDX_ONE   = Addr_Width'(1);

    typedef logic [Para_Deg-1:0][Data_Width_In-1:0]  in_word_t;
    typedef logic [Para_Deg-1:0][Data_Width_Out-1:0] out_word_t;
    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DUMP} mode_e;

    in_word_t  mem0 [2**Addr_Width];
    in_word_t  mem1 [2**Addr_Width];
    out_word_t memo [2**Addr_Width];

    mode_e                 mode_q;
    logic [Addr_Width-1:0] idx_q;
    logic [CW-1:0]         cnt_q;
    logic [SW-1:0]         state_q;
    logic                  load_old_q;

    in_word_t  in0_word, in1_word;
    in_word_t  rd0_d, rd0_q, rd1_d, rd1_q;
    out_word_t rdo_d, rdo_q, sum_w, result_d, result_q, dout_d, dout_q;
    out_word_t out_wdata;
    logic [Addr_Width-1:0] out_waddr;
    logic                  issue, load_we, out_we;

    // vld_pipe_q[0]: read data valid, [1]: product valid, [2]: sum valid (write-back)
    logic [2:0]            vld_pipe_d, vld_pipe_q;
    logic [Addr_Width-1:0] addr_pipe_d [3];
    logic [Addr_Width-1:0] addr_pipe_q [3];

    assign in0_word = input_data_from_file[PW_IN-1:0];
    assign in1_word = input_data_from_file[2*PW_IN-1:PW_IN];
    assign issue    = (mode_q == COMPUTE) && (state_q <= ST_ISSUE);
    assign load_we  = (mode_q == LOAD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q     <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            state_q    <= '0;
            load_old_q <= 1'b0;
        end else begin
            case (mode_q)
                IDLE: begin
                    if (load_from_file) begin
                        mode_q <= LOAD;
                        idx_q  <= '0;
                        cnt_q  <= '0;
                    end else if (write_to_file) begin
                        mode_q <= DUMP;
                        idx_q  <= '0;
                        cnt_q  <= '0;
                    end else if (Computing) begin
                        mode_q     <= COMPUTE;
                        idx_q      <= '0;
                        state_q    <= ST_ONE;
                        load_old_q <= load_old_output;
                    end
                end
                LOAD, DUMP: begin
                    idx_q <= idx_q + IDX_ONE;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) mode_q <= IDLE;
                end
                COMPUTE: begin
                    if (issue) idx_q <= idx_q + IDX_ONE;
                    if (state_q == ST_LAST) begin
                        state_q <= '0;
                        mode_q  <= IDLE;
                    end else begin
                        state_q <= state_q + ST_ONE;
                    end
                end
                default: mode_q <= IDLE;
            endcase
            // Index clear wins over any increment or start-pulse clear above
            if (Mem_Index_reset) idx_q <= '0;
        end
    end

    always_comb begin
        vld_pipe_d     = {vld_pipe_q[1:0], issue};
        addr_pipe_d[0] = idx_q;
        addr_pipe_d[1] = addr_pipe_q[0];
        addr_pipe_d[2] = addr_pipe_q[1];
        rd0_d          = issue ? mem0[idx_q] : rd0_q;
        rd1_d          = issue ? mem1[idx_q] : rd1_q;
        rdo_d          = issue ? memo[idx_q] : rdo_q;
        result_d       = vld_pipe_q[2] ? sum_w : result_q;
        dout_d         = (mode_q == DUMP) ? memo[idx_q] : dout_q;
        out_we         = load_we | vld_pipe_q[2];
        out_waddr      = load_we ? idx_q : addr_pipe_q[2];
        out_wdata      = load_we ? out_word_t'(output_data_from_file) : sum_w;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe_q <= '0;
            for (int i = 0; i < 3; i++) addr_pipe_q[i] <= '0;
            result_q   <= '0;
            dout_q     <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            for (int i = 0; i < 3; i++) addr_pipe_q[i] <= addr_pipe_d[i];
            result_q   <= result_d;
            dout_q     <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        rd0_q <= rd0_d;
        rd1_q <= rd1_d;
        rdo_q <= rdo_d;
        if (load_we) begin
            mem0[idx_q] <= in0_word;
            mem1[idx_q] <= in1_word;
        end
        if (out_we) memo[out_waddr] <= out_wdata;
    end

    for (genvar j = 0; j < Para_Deg; j++) begin : g_lane
        dot_product_lane #(
            .Din  (Data_Width_In),
            .Dout (Data_Width_Out)
        ) u_lane (
            .clk (clk),
            .a   (rd0_q[j]),
            .b   (rd1_q[j]),
            .old (rdo_q[j]),
            .acc (load_old_q),
            .sum (sum_w[j])
        );
    end

    assign output_data_to_file = dout_q;
    assign result              = result_q;
    assign state               = state_q;

`ifdef DOT_PRODUCT_DEBUG_EN
    assign test_r         = {idx_q, idx_q, idx_q};
    assign test_w         = {out_waddr, idx_q, idx_q};
    assign test_data      = {rd1_q, rd0_q};
    assign en_write_test  = out_we;
    assign mem_index_test = {1'b0, idx_q};
    assign test_en_read   = issue;
    assign test_signal    = write_to_file;
`endif
endmodule

// File: tb/tb_dot_product.sv
// Randomized and directed bench for dot_product against an array-based reference model.

module tb_dot_product;
    localparam int AW = 4, P = 2, DI = 8, DO = 16, NB = 4, PS = 4;
    localparam int W = (1 << NB) / P;
    localparam int T = W + PS - 1;
    localparam int PW_IN = P * DI, PW_OUT = P * DO;

    logic clk = 1'b0, reset_n = 1'b0;
    logic Mem_Index_reset = 1'b0, Computing = 1'b0, load_old_output = 1'b0;
    logic load_from_file = 1'b0, write_to_file = 1'b0;
    logic [2*PW_IN-1:0] input_data_from_file = '0;
    logic [PW_OUT-1:0]  output_data_from_file = '0;
    logic [PW_OUT-1:0]  output_data_to_file, result;
    logic [NB:0]        state;

    logic [DI-1:0] m0 [W][P];
    logic [DI-1:0] m1 [W][P];
    logic [DO-1:0] mo [W][P];
    int n_chk = 0, n_fail = 0;

    dot_product #(
        .Addr_Width(AW), .Para_Deg(P), .Data_Width_In(DI), .Data_Width_Out(DO),
        .Nums_Data_in_bits(NB), .Nums_Pipeline_Stages(PS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .Mem_Index_reset(Mem_Index_reset),
        .Computing(Computing), .load_old_output(load_old_output),
        .load_from_file(load_from_file), .write_to_file(write_to_file),
        .input_data_from_file(input_data_from_file),
        .output_data_from_file(output_data_from_file),
        .output_data_to_file(output_data_to_file), .result(result), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW_OUT-1:0] out_word(input int k);
        logic [PW_OUT-1:0] r;
        for (int j = 0; j < P; j++) r[j*DO +: DO] = mo[k][j];
        return r;
    endfunction

    task automatic run_load();
        @(posedge clk); #1 load_from_file = 1'b1;
        @(posedge clk); #1 load_from_file = 1'b0;
        for (int k = 0; k < W; k++) begin
            for (int j = 0; j < P; j++) begin
                input_data_from_file[j*DI +: DI]         = m0[k][j];
                input_data_from_file[PW_IN + j*DI +: DI] = m1[k][j];
                output_data_from_file[j*DO +: DO]        = mo[k][j];
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_compute(input bit l);
        for (int k = 0; k < W; k++)
            for (int j = 0; j < P; j++)
                mo[k][j] = DO'((l ? int'(mo[k][j]) : 0) + int'(m0[k][j]) * int'(m1[k][j]));
        @(posedge clk); #1 Computing = 1'b1; load_old_output = l;
        @(posedge clk); #1 Computing = 1'b0; load_old_output = 1'b0;
        for (int s = 1; s <= T; s++) begin
            chk("state_step", state, s);
            if (s >= 5) chk("result_step", result, out_word(s - 5));
            // a second start pulse mid-compute must be ignored
            if (s == 3) Computing = 1'b1;
            @(posedge clk); #1 Computing = 1'b0;
        end
        chk("state_end", state, 0);
        chk("result_end", result, out_word(W - 1));
    endtask

    task automatic run_dump(input int mir_at);
        int ptr;
        logic [PW_OUT-1:0] last;
        ptr  = 0;
        last = '0;
        @(posedge clk); #1 write_to_file = 1'b1;
        @(posedge clk); #1 write_to_file = 1'b0;
        for (int c = 0; c < W; c++) begin
            Mem_Index_reset = (c == mir_at);
            @(posedge clk); #1 Mem_Index_reset = 1'b0;
            last = out_word(ptr);
            chk("dump_word", output_data_to_file, last);
            ptr = (c == mir_at) ? 0 : ptr + 1;
        end
        @(posedge clk); #1 chk("dump_hold", output_data_to_file, last);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_result", result, 0);
        chk("rst_dout", output_data_to_file, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        for (int k = 0; k < W; k++)
            for (int j = 0; j < P; j++) begin
                m0[k][j] = DI'(k*P + j + 1);
                m1[k][j] = 8'd2;
                mo[k][j] = '0;
            end
        run_load(); run_compute(1'b0); run_dump(-1);

        for (int k = 0; k < W; k++)
            for (int j = 0; j < P; j++) mo[k][j] = 16'd100;
        run_load(); run_compute(1'b1); run_dump(-1); run_dump(3);

        for (int k = 0; k < W; k++)
            for (int j = 0; j < P; j++) begin
                m0[k][j] = 8'd255;
                m1[k][j] = 8'd255;
                mo[k][j] = 16'hFFFF;
            end
        run_load(); run_compute(1'b1); run_dump(-1);
        chk("wrap_word0", out_word(0), {2{16'd65024}});

        for (int r = 0; r < 4; r++) begin
            int mir;
            for (int k = 0; k < W; k++)
                for (int j = 0; j < P; j++) begin
                    m0[k][j] = DI'($urandom);
                    m1[k][j] = DI'($urandom);
                    mo[k][j] = DO'($urandom);
                end
            mir = int'($urandom_range(0, W));
            run_load();
            run_compute(1'($urandom_range(0, 1)));
            run_dump(mir == W ? -1 : mir);
        end
        run_compute(1'b1); run_dump(-1);

        @(posedge clk); #1 Computing = 1'b1;
        @(posedge clk); #1 Computing = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b0;
        #1 chk("midrst_state", state, 0);
        chk("midrst_result", result, 0);
        chk("midrst_dout", output_data_to_file, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("post_rst_idle", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dot_product.md
DOT_PRODUCT -- requirements
Module: dot_product

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-002 Parameters (name, default, meaning):
- Addr_Width, 4: SRAM address width.
- Para_Deg, 2: lanes per SRAM word.
- Data_Width_In, 8: unsigned input element width.
- Data_Width_Out, 16: unsigned output element width.
- Nums_Data_in_bits, 4: log2 of element count N (16).
- Nums_Pipeline_Stages, 4: compute pipeline depth.
- Derived: W = N/Para_Deg words (8); T = W + Nums_Pipeline_Stages - 1 compute steps (11).
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- reset_n, in, 1: async active-low reset.
- Mem_Index_reset, in, 1: synchronous clear of the shared word index.
- Computing, in, 1: start-compute pulse.
- load_old_output, in, 1: sampled with Computing; 1 accumulates onto the old output SRAM.
- load_from_file, in, 1: start-load pulse.
- write_to_file, in, 1: start-dump pulse.
- input_data_from_file, in, 2*Para_Deg*Data_Width_In: SRAM0 word in [Para_Deg*Data_Width_In-1:0], SRAM1 word above it; lane j at j*Data_Width_In.
- output_data_from_file, in, Para_Deg*Data_Width_Out: output SRAM load word.
- output_data_to_file, out, Para_Deg*Data_Width_Out: output SRAM dump word.
- result, out, Para_Deg*Data_Width_Out: last word written by compute.
- state, out, Nums_Data_in_bits+1: compute step counter.

Function
REQ-004 The block SHALL hold three SRAMs of 2^Addr_Width words: in0 and in1 (Para_Deg x Data_Width_In per word) and out (Para_Deg x Data_Width_Out per word). Only words 0..W-1 are used.
REQ-005 The controller SHALL have modes IDLE, LOAD, COMPUTE and DUMP. Start pulses are honoured only in IDLE, with priority load_from_file > write_to_file > Computing. Pulses in any other mode are ignored.
REQ-006 LOAD: the pulse clears the index. On each of the next W cycles, all three SRAMs SHALL write the current port words at address index, and index increments. The block then returns to IDLE.
REQ-007 COMPUTE: for each word k and lane j, out[k][j] SHALL become (L ? out[k][j] : 0) + in0[k][j]*in1[k][j]. L is load_old_output latched with Computing.
REQ-008 The pipeline SHALL have 4 stages: read, multiply, add, write-back. The word issued at step s is written at step s+3.
REQ-009 state SHALL count 1..T during COMPUTE and return to 0 with the mode going to IDLE after step T.
REQ-010 The product SHALL be Data_Width_Out bits unsigned. The sum SHALL wrap modulo 2^Data_Width_Out.
REQ-011 result SHALL update with each write-back word and hold its value otherwise.
REQ-012 DUMP: the pulse clears the index. On each of the next W cycles, output_data_to_file SHALL present registered out[index], with index incrementing. It holds the last word afterwards.
REQ-013 Mem_Index_reset SHALL clear the index on the next edge in any mode and SHALL NOT change the mode.
REQ-014 The index SHALL wrap modulo 2^Addr_Width.

Reset
REQ-015 While reset_n is low, the block SHALL set mode IDLE, index 0, state 0, result 0 and output_data_to_file 0, and clear pipeline valid bits. SRAM contents are undefined.
REQ-016 Deasserting reset_n mid-operation SHALL leave the block in IDLE. A partially computed out SRAM is not restored.

Configuration
REQ-017 With DOT_PRODUCT_DEBUG_EN defined, the block SHALL add the following debug outputs:
- test_r and test_w, 3*Addr_Width: per-SRAM read and write addresses.
- test_data, 2*Para_Deg*Data_Width_In: in0/in1 read words.
- en_write_test, 1: out-SRAM write enable.
- mem_index_test, Addr_Width+1: index.
- test_en_read, 1: read enable.
- test_signal, 1: write_to_file.
REQ-018 Without DOT_PRODUCT_DEBUG_EN, these debug ports SHALL NOT exist and function SHALL be identical.

Verification
REQ-019 Reset with reset_n=0 -> state=0, result=0, output_data_to_file=0.
REQ-020 Load in0 = 1..16, in1 = 2 (all elements), out = 0; Computing with L=0; dump -> out = 2,4,...,32.
REQ-021 Same data with out preloaded 100 and L=1 -> out = 102,104,...,132.
REQ-022 in0 = in1 = 255, L=1, out preloaded 65535 -> out = 65024, showing modulo wrap.
REQ-023 After a Computing pulse -> state goes 1..11 on consecutive cycles, then 0. A Computing pulse during COMPUTE is ignored.
REQ-024 Mem_Index_reset asserted mid-DUMP -> the next dumped word is word 0.
